// File: rtl/lock_pkg.sv
// lock_pkg: lock state codes, glyph ids and active-low segment
// patterns shared by the lock display top level and glyph map.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_INPUT  = 3'd1,
        ST_UNLOCK = 3'd2,
        ST_ERROR  = 3'd3,
        ST_ALARM  = 3'd4,
        ST_ADMIN  = 3'd5
    } lock_state_t;

    // Digits sit at their own value so a BCD nibble maps directly.
    typedef enum logic [4:0] {
        G_0     = 5'd0,
        G_1     = 5'd1,
        G_2     = 5'd2,
        G_3     = 5'd3,
        G_4     = 5'd4,
        G_5     = 5'd5,
        G_6     = 5'd6,
        G_7     = 5'd7,
        G_8     = 5'd8,
        G_9     = 5'd9,
        G_DASH  = 5'd10,
        G_BLANK = 5'd11,
        G_A     = 5'd12,
        G_U     = 5'd13,
        G_O     = 5'd14,
        G_P     = 5'd15,
        G_E     = 5'd16,
        G_N     = 5'd17,
        G_R     = 5'd18,
        G_8DP   = 5'd19
    } glyph_t;

    // {DP,g,f,e,d,c,b,a}, active-low
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_U     = 8'hC1;
    localparam logic [7:0] SEG_O     = 8'hC0;
    localparam logic [7:0] SEG_P     = 8'h8C;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_N     = 8'hAB;
    localparam logic [7:0] SEG_R     = 8'hAF;
    localparam logic [7:0] SEG_8DP   = 8'h00;

    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Non-decimal nibbles render as a dash.
    function automatic glyph_t bcd_glyph(input logic [3:0] d);
        if (d > 4'd9) begin
            return G_DASH;
        end
        return glyph_t'({1'b0, d});
    endfunction

endpackage

// File: rtl/lock_seg_glyph.sv
// lock_seg_glyph: combinational glyph id to segment pattern map.
// Ports: glyph (id from lock_pkg), seg (active-low {DP,g..a}).
module lock_seg_glyph
    import lock_pkg::*;
(
    input  logic [4:0] glyph,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (glyph)
            G_0:     seg = SEG_0;
            G_1:     seg = SEG_1;
            G_2:     seg = SEG_2;
            G_3:     seg = SEG_3;
            G_4:     seg = SEG_4;
            G_5:     seg = SEG_5;
            G_6:     seg = SEG_6;
            G_7:     seg = SEG_7;
            G_8:     seg = SEG_8;
            G_9:     seg = SEG_9;
            G_DASH:  seg = SEG_DASH;
            G_A:     seg = SEG_A;
            G_U:     seg = SEG_U;
            G_O:     seg = SEG_O;
            G_P:     seg = SEG_P;
            G_E:     seg = SEG_E;
            G_N:     seg = SEG_N;
            G_R:     seg = SEG_R;
            G_8DP:   seg = SEG_8DP;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/lock_display.sv
// lock_display: 8-digit multiplexed 7-segment and LED front end for a
// keypad lock, showing entry, status and a blinking alarm pattern.
// Ports: CLK, RESET_N (async, active-low); STATE, CODE, CODE_BIT,
// ERROR_TIME, ID_FLAG status in; AN/SEG active-low digit drive out;
// LED active-high status out.
module lock_display
    import lock_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SCAN_HZ     = 8000,
    parameter int BLINK_TICKS = 2000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [2:0]  STATE,
    input  logic [15:0] CODE,
    input  logic [2:0]  CODE_BIT,
    input  logic [1:0]  ERROR_TIME,
    input  logic        ID_FLAG,
    output logic [7:0]  AN,
    output logic [7:0]  SEG,
    output logic [15:0] LED
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic [2:0]    state_q;
    logic [15:0]   code_q;
    logic [2:0]    bit_q;
    logic [1:0]    err_q;
    logic          id_q;

    logic [CW-1:0] pre_cnt;
    logic          tick_q;
    logic [2:0]    idx;
    logic [BW-1:0] blink_cnt;
    logic          dark;

    logic [2:0]    idx_next;
    logic [BW-1:0] blink_nx;
    logic          dark_nx;
    logic          valid;
    logic          alarm;
    glyph_t        glyph;
    logic [7:0]    glyph_seg;
    logic [3:0]    therm;
    logic [15:0]   led_nx;

    assign idx_next = idx + 3'd1;
    assign valid    = (state_q <= 3'd5);
    assign alarm    = (state_q == ST_ALARM);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= '0;
            code_q  <= '0;
            bit_q   <= '0;
            err_q   <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= STATE;
            code_q  <= CODE;
            bit_q   <= CODE_BIT;
            err_q   <= ERROR_TIME;
            id_q    <= ID_FLAG;
        end
    end

    // tick_q is a registered one-cycle pulse; outputs follow it one
    // cycle later together with the digit index.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
            idx     <= '0;
        end else begin
            if (pre_cnt == DIV_LAST) begin
                pre_cnt <= '0;
                tick_q  <= 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
                tick_q  <= 1'b0;
            end
            if (tick_q) begin
                idx <= idx_next;
            end
        end
    end

    // Held cleared outside ALARM, so every entry starts visible.
    always_comb begin
        blink_nx = blink_cnt;
        dark_nx  = dark;
        if (!alarm) begin
            blink_nx = '0;
            dark_nx  = 1'b0;
        end else if (tick_q) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_nx = '0;
                dark_nx  = ~dark;
            end else begin
                blink_nx = blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            blink_cnt <= '0;
            dark      <= 1'b0;
        end else begin
            blink_cnt <= blink_nx;
            dark      <= dark_nx;
        end
    end

    always_comb begin
        glyph = G_BLANK;
        case (state_q)
            ST_WAIT: begin
                if (!idx_next[2]) glyph = G_DASH;
            end
            ST_INPUT, ST_ADMIN: begin
                if (!idx_next[2]) begin
                    if ({1'b0, idx_next[1:0]} < bit_q)
                        glyph = bcd_glyph(
                            code_q[{idx_next[1:0], 2'b00} +: 4]);
                    else
                        glyph = G_DASH;
                end else if (idx_next == 3'd7) begin
                    glyph = id_q ? G_A : G_U;
                end
            end
            ST_UNLOCK: begin
                case (idx_next)
                    3'd3:    glyph = G_O;
                    3'd2:    glyph = G_P;
                    3'd1:    glyph = G_E;
                    3'd0:    glyph = G_N;
                    default: glyph = G_BLANK;
                endcase
            end
            ST_ERROR: begin
                case (idx_next)
                    3'd7:    glyph = G_E;
                    3'd6:    glyph = G_R;
                    3'd5:    glyph = G_R;
                    3'd0:    glyph = bcd_glyph({2'b00, err_q});
                    default: glyph = G_BLANK;
                endcase
            end
            ST_ALARM: glyph = G_8DP;
            default:  glyph = G_BLANK;
        endcase
    end

    lock_seg_glyph u_glyph (
        .glyph (glyph),
        .seg   (glyph_seg)
    );

    always_comb begin
        case (bit_q)
            3'd0:    therm = 4'b0000;
            3'd1:    therm = 4'b0001;
            3'd2:    therm = 4'b0011;
            3'd3:    therm = 4'b0111;
            default: therm = 4'b1111;
        endcase
    end

    always_comb begin
        led_nx = '0;
        if (!valid) begin
            led_nx = '0;
        end else if (alarm) begin
            led_nx = dark_nx ? 16'h0000 : 16'hFFFF;
        end else begin
            led_nx[3:0]   = therm;
            led_nx[12]    = err_q[0];
            led_nx[13]    = err_q[1];
            led_nx[14]    = id_q;
            led_nx[15]    = (state_q == ST_UNLOCK);
        end
    end

    // Invalid states blank immediately; otherwise the digit
    // drive only changes on a scan tick.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            AN  <= AN_OFF;
            SEG <= SEG_BLANK;
            LED <= '0;
        end else begin
            LED <= led_nx;
            if (!valid) begin
                AN  <= AN_OFF;
                SEG <= SEG_BLANK;
            end else if (tick_q) begin
                if (alarm && dark_nx) begin
                    AN  <= AN_OFF;
                    SEG <= SEG_BLANK;
                end else begin
                    AN  <= ~(8'b1 << idx_next);
                    SEG <= glyph_seg;
                end
            end
        end
    end

endmodule

// File: tb/tb_lock_display.sv
// tb_lock_display: self-checking bench for lock_display with a
// text-level display model and randomized status patterns.
module tb_lock_display;

    localparam int CLK_HZ      = 16;
    localparam int SCAN_HZ     = 4;
    localparam int BLINK_TICKS = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  state = '0;
    logic [15:0] code = '0;
    logic [2:0]  code_bit = '0;
    logic [1:0]  error_time = '0;
    logic        id_flag = 1'b0;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [15:0] led;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] cap [8];

    lock_display #(
        .CLK_HZ      (CLK_HZ),
        .SCAN_HZ     (SCAN_HZ),
        .BLINK_TICKS (BLINK_TICKS)
    ) dut (
        .CLK        (clk),
        .RESET_N    (reset_n),
        .STATE      (state),
        .CODE       (code),
        .CODE_BIT   (code_bit),
        .ERROR_TIME (error_time),
        .ID_FLAG    (id_flag),
        .AN         (an),
        .SEG        (seg),
        .LED        (led)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Display text, position 0 = leftmost digit (digit 7).
    // '#' is an 8 with the decimal point lit.
    function automatic string disp_text(input logic [2:0] st,
                                        input logic [15:0] cd,
                                        input logic [2:0] nb,
                                        input logic [1:0] et,
                                        input logic idf);
        string s;
        int d;
        s = "        ";
        case (st)
            3'd0: s = "    ----";
            3'd1, 3'd5: begin
                s = idf ? "A       " : "U       ";
                for (int k = 0; k < 4; k++) begin
                    d = int'((cd >> (4 * k)) & 16'hF);
                    if (k < int'(nb) && d <= 9)
                        s.putc(7 - k, 8'(8'h30 + d));
                    else
                        s.putc(7 - k, 8'h2D);
                end
            end
            3'd2: s = "    OPEN";
            3'd3: begin
                s = "Err     ";
                s.putc(7, 8'(8'h30 + int'(et)));
            end
            3'd4: s = "########";
            default: s = "        ";
        endcase
        return s;
    endfunction

    function automatic logic [7:0] seg_of(input byte c);
        string lit;
        logic [7:0] v;
        int ix;
        case (c)
            "0": lit = "abcdef";
            "1": lit = "bc";
            "2": lit = "abdeg";
            "3": lit = "abcdg";
            "4": lit = "bcfg";
            "5": lit = "acdfg";
            "6": lit = "acdefg";
            "7": lit = "abc";
            "8": lit = "abcdefg";
            "9": lit = "abcdfg";
            "-": lit = "g";
            "A": lit = "abcefg";
            "U": lit = "bcdef";
            "O": lit = "abcdef";
            "P": lit = "abefg";
            "E": lit = "adefg";
            "N": lit = "ceg";
            "r": lit = "eg";
            "#": lit = "abcdefg.";
            default: lit = "";
        endcase
        v = 8'hFF;
        for (int i = 0; i < lit.len(); i++) begin
            if (lit.getc(i) == ".") begin
                v[7] = 1'b0;
            end else begin
                ix = int'(lit.getc(i)) - 97;
                v[ix[2:0]] = 1'b0;
            end
        end
        return v;
    endfunction

    function automatic logic [15:0] led_model(input logic [2:0] st,
                                              input logic [2:0] nb,
                                              input logic [1:0] et,
                                              input logic idf);
        int t;
        int r;
        if (st > 3'd5) return 16'h0;
        t = (nb >= 4) ? 15 : (1 << nb) - 1;
        r = t + (int'(et) * 4096) + (int'(idf) * 16384);
        if (st == 3'd2) r = r + 32768;
        return 16'(r);
    endfunction

    function automatic int digit_of(input logic [7:0] a);
        int r;
        logic [7:0] m;
        r = -1;
        for (int i = 0; i < 8; i++) begin
            m = 8'h01 << i;
            if (a === ~m) r = i;
        end
        return r;
    endfunction

    task automatic wait_an(input logic [7:0] v, input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (an !== v && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (an !== v) begin
            n_fail++;
            $display("FAIL %s timeout an=%h want %h", tag, an, v);
        end
    endtask

    task automatic capture();
        int d;
        for (int i = 0; i < 8; i++) cap[i] = 8'h5A;
        repeat (34) @(negedge clk);
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            d = digit_of(an);
            if (d >= 0) cap[d] = seg;
        end
    endtask

    task automatic scan_check(input string tag);
        string txt;
        int d;
        logic [7:0] e;
        logic [15:0] el;
        txt = disp_text(state, code, code_bit, error_time, id_flag);
        el = led_model(state, code_bit, error_time, id_flag);
        repeat (34) @(negedge clk);
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            d = digit_of(an);
            n_checks++;
            if (d < 0) begin
                n_fail++;
                $display("FAIL %s_an an=%h not one-hot-low", tag, an);
            end else begin
                e = seg_of(txt.getc(7 - d));
                if (seg !== e) begin
                    n_fail++;
                    $display("FAIL %s_seg st=%0d digit=%0d seg=%h want %h",
                             tag, state, d, seg, e);
                end
            end
            n_checks++;
            if (led !== el) begin
                n_fail++;
                $display("FAIL %s_led led=%h want %h", tag, led, el);
            end
        end
    endtask

    task automatic test_reset();
        state = 3'd0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (an !== 8'hFF || seg !== 8'hFF || led !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_async an=%h seg=%h led=%h want ff/ff/0000",
                     an, seg, led);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (an !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_pre_tick an=%h want ff", an);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (an !== 8'hFD) begin
            n_fail++;
            $display("FAIL reset_first_tick an=%h want fd", an);
        end
    endtask

    task automatic test_wait_walk();
        string txt;
        logic [7:0] ea;
        logic [7:0] es;
        int d;
        txt = disp_text(3'd0, 16'h0, 3'd0, 2'd0, 1'b0);
        wait_an(8'hFE, "walk_sync");
        for (int n = 0; n < 36; n++) begin
            if (n > 0) @(negedge clk);
            d = (n / 4) % 8;
            ea = 8'h01 << d;
            ea = ~ea;
            n_checks++;
            if (an !== ea) begin
                n_fail++;
                $display("FAIL walk_an cycle=%0d an=%h want %h", n, an, ea);
            end
            es = seg_of(txt.getc(7 - d));
            n_checks++;
            if (seg !== es) begin
                n_fail++;
                $display("FAIL walk_seg cycle=%0d seg=%h want %h", n, seg, es);
            end
        end
    endtask

    task automatic test_input_code();
        @(negedge clk);
        state = 3'd1;
        code = 16'h0937;
        code_bit = 3'd2;
        error_time = 2'd0;
        id_flag = 1'b0;
        capture();
        n_checks++;
        if (cap[0] !== 8'hF8) begin
            n_fail++;
            $display("FAIL input_d0 seg=%h want f8", cap[0]);
        end
        n_checks++;
        if (cap[1] !== 8'hB0) begin
            n_fail++;
            $display("FAIL input_d1 seg=%h want b0", cap[1]);
        end
        n_checks++;
        if (cap[2] !== 8'hBF || cap[3] !== 8'hBF) begin
            n_fail++;
            $display("FAIL input_d23 seg=%h/%h want bf/bf", cap[2], cap[3]);
        end
        n_checks++;
        if (cap[7] !== seg_of("U")) begin
            n_fail++;
            $display("FAIL input_d7 seg=%h want %h", cap[7], seg_of("U"));
        end
        n_checks++;
        if (led[3:0] !== 4'b0011) begin
            n_fail++;
            $display("FAIL input_led led=%h want xxx3", led);
        end
    endtask

    task automatic test_error_digit();
        @(negedge clk);
        state = 3'd3;
        error_time = 2'd2;
        capture();
        n_checks++;
        if (cap[0] !== 8'hA4) begin
            n_fail++;
            $display("FAIL error_d0 seg=%h want a4", cap[0]);
        end
        n_checks++;
        if (cap[7] !== seg_of("E")) begin
            n_fail++;
            $display("FAIL error_d7 seg=%h want %h", cap[7], seg_of("E"));
        end
        n_checks++;
        if (led[13:12] !== 2'b10) begin
            n_fail++;
            $display("FAIL error_led led=%h want bits13:12=10", led);
        end
    endtask

    task automatic test_random_display();
        int pick;
        for (int it = 0; it < 15; it++) begin
            @(negedge clk);
            pick = int'($urandom_range(0, 4));
            state = (pick == 4) ? 3'd5 : 3'(pick);
            code = 16'($urandom);
            code_bit = 3'($urandom_range(0, 7));
            error_time = 2'($urandom_range(0, 3));
            id_flag = 1'($urandom_range(0, 1));
            scan_check("rand");
        end
    endtask

    task automatic test_alarm_blink();
        logic [15:0] prev;
        int run;
        int toggles;
        bit started;
        bit lit;
        @(negedge clk);
        state = 3'd0;
        code_bit = 3'd0;
        error_time = 2'd0;
        id_flag = 1'b0;
        repeat (4) @(negedge clk);
        state = 3'd4;
        started = 0;
        run = 0;
        toggles = 0;
        prev = 16'h0;
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            n_checks++;
            if (led !== 16'hFFFF && led !== 16'h0000) begin
                n_fail++;
                $display("FAIL alarm_led_value led=%h want ffff or 0000", led);
            end
            if (n >= 8) begin
                lit = (an !== 8'hFF);
                n_checks++;
                if (lit !== (led === 16'hFFFF)) begin
                    n_fail++;
                    $display("FAIL alarm_phase an=%h led=%h", an, led);
                end
                if (lit) begin
                    n_checks++;
                    if (seg !== 8'h00 || digit_of(an) < 0) begin
                        n_fail++;
                        $display("FAIL alarm_lit an=%h seg=%h want seg 00",
                                 an, seg);
                    end
                end
            end
            if (!started) begin
                if (led === 16'hFFFF) begin
                    started = 1;
                    run = 1;
                end
            end else if (led === prev) begin
                run++;
            end else begin
                toggles++;
                n_checks++;
                if ((toggles == 1) ? (run < 1 || run > 8) : (run != 8)) begin
                    n_fail++;
                    $display("FAIL alarm_half_period n=%0d run=%0d want 8",
                             toggles, run);
                end
                run = 1;
            end
            prev = led;
        end
        n_checks++;
        if (toggles < 7) begin
            n_fail++;
            $display("FAIL alarm_toggles count=%0d want >=7", toggles);
        end
    endtask

    task automatic test_alarm_reentry();
        int k;
        k = 0;
        @(negedge clk);
        while (led !== 16'h0000 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (led !== 16'h0000) begin
            n_fail++;
            $display("FAIL reentry_dark timeout led=%h want 0000", led);
        end
        state = 3'd0;
        repeat (3) @(negedge clk);
        state = 3'd4;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int n = 0; n < 3; n++) begin
            if (n > 0) @(negedge clk);
            n_checks++;
            if (led !== 16'hFFFF) begin
                n_fail++;
                $display("FAIL reentry_visible n=%0d led=%h want ffff", n, led);
            end
        end
    endtask

    task automatic test_invalid_state();
        @(negedge clk);
        state = 3'd1;
        code = 16'h1234;
        code_bit = 3'd4;
        repeat (40) @(negedge clk);
        state = 3'd7;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (an !== 8'hFF || seg !== 8'hFF || led !== 16'h0) begin
            n_fail++;
            $display("FAIL invalid7 an=%h seg=%h led=%h want ff/ff/0000",
                     an, seg, led);
        end
        state = 3'd6;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            n_checks++;
            if (an !== 8'hFF || seg !== 8'hFF || led !== 16'h0) begin
                n_fail++;
                $display("FAIL invalid6 an=%h seg=%h led=%h want ff/ff/0000",
                         an, seg, led);
            end
        end
        state = 3'd1;
        scan_check("resume");
    endtask

    task automatic test_reset_mid_alarm();
        @(negedge clk);
        state = 3'd4;
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (an !== 8'hFF || seg !== 8'hFF || led !== 16'h0) begin
            n_fail++;
            $display("FAIL alarm_reset an=%h seg=%h led=%h want ff/ff/0000",
                     an, seg, led);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (an !== 8'hFF || seg !== 8'hFF || led !== 16'h0) begin
            n_fail++;
            $display("FAIL alarm_reset_hold an=%h seg=%h led=%h", an, seg, led);
        end
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (an !== 8'hFF) begin
            n_fail++;
            $display("FAIL alarm_rel_pre an=%h want ff", an);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (an !== 8'hFD || seg !== 8'h00 || led !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL alarm_rel_first an=%h seg=%h led=%h want fd/00/ffff",
                     an, seg, led);
        end
    endtask

    initial begin
        test_reset();
        test_wait_walk();
        test_input_code();
        test_error_digit();
        test_random_display();
        test_alarm_blink();
        test_alarm_reentry();
        test_invalid_state();
        test_reset_mid_alarm();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lock_display.md
LOCK_DISPLAY -- requirements
Module: lock_display

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000: system clock frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 8000: digit-advance rate, giving 1 kHz per digit over 8 digits.
REQ-003 Parameter BLINK_TICKS, default 2000: scan ticks per ALARM blink half-period.
REQ-004 CLK  in  1  system clock; the only clock in the block.
REQ-005 RESET_N  in  1  reset, asynchronous and active-low.
REQ-006 STATE  in  3  lock state: WAIT=0, INPUT=1, UNLOCK=2, ERROR=3, ALARM=4, ADMIN=5.
REQ-007 CODE  in  16  four BCD digits; digit k is CODE[4k+3:4k].
REQ-008 CODE_BIT  in  3  count of entered digits, 0..4.
REQ-009 ERROR_TIME  in  2  wrong-attempt count.
REQ-010 ID_FLAG  in  1  1 = admin, 0 = user.
REQ-011 AN  out  8  digit enables, active-low, one-hot-low while scanning.
REQ-012 SEG  out  8  segments, active-low; {DP,g,f,e,d,c,b,a}.
REQ-013 LED  out  16  status LEDs, active-high.

Function
REQ-014 A prescaler shall emit a one-cycle scan tick every CLK_HZ/SCAN_HZ cycles; the prescaler counter wraps to 0 on the tick.
REQ-015 A 3-bit digit index shall increment on each tick and wrap from 7 to 0.
REQ-016 AN and SEG shall be registered and update on the cycle after the tick, to the digit index and glyph for the new index.
REQ-017 All inputs shall be registered once per clock; any input change shall appear on its digit within 8 scan periods plus 2 cycles.
REQ-018 Glyph encodings: digits 0-9 standard; '-' = 8'hBF; blank = 8'hFF; BCD digit values above 9 shall display as '-'.
REQ-019 WAIT: digits 3:0 show '-'; digits 7:4 blank.
REQ-020 INPUT/ADMIN: digit k (k = 0..3) shows BCD digit k when k < CODE_BIT, otherwise '-'; digit 7 shows 'A' when ID_FLAG = 1, otherwise 'U'; digits 6:4 blank.
REQ-021 UNLOCK: digits 3:0 show "OPEN"; all other digits blank.
REQ-022 ERROR: digits 7:5 show "Err"; digit 0 shows ERROR_TIME as a decimal digit; all other digits blank.
REQ-023 ALARM: all 8 digits show '8' with DP lit (SEG = 8'h00) in the visible phase; AN = 8'hFF in the dark phase.
REQ-024 Blink phase shall toggle every BLINK_TICKS scan ticks.
REQ-025 Blink counter and phase shall be cleared to visible on every entry into ALARM.
REQ-026 LED, states other than ALARM: LED[3:0] = thermometer code of CODE_BIT (CODE_BIT > 4 saturates to 4'b1111); LED[12] and LED[13] = ERROR_TIME[0] and ERROR_TIME[1]; LED[14] = ID_FLAG; LED[15] = (STATE == UNLOCK); all other LED bits 0.
REQ-027 LED, ALARM: LED = 16'hFFFF in the visible phase and 16'h0000 in the dark phase.
REQ-028 STATE 6 or 7: AN = 8'hFF, SEG = 8'hFF, LED = 0; scanning continues.

Reset
REQ-029 While RESET_N = 0, outputs shall be AN = 8'hFF, SEG = 8'hFF, LED = 0, with no clock edge required.
REQ-030 While RESET_N = 0, the prescaler, digit index, blink counter, and input registers shall be 0, and the blink phase shall be visible.
REQ-031 Reset asserted mid-scan or mid-blink shall abort immediately; the first tick after release shall select digit 1.

Structure
REQ-032 Package lock_pkg shall hold the state encodings, glyph identifiers, and segment constants, shared with the lock top level.
REQ-033 The glyph-to-segment map shall be a combinational sub-module, lock_seg_glyph.

Verification (CLK_HZ = 16, SCAN_HZ = 4, BLINK_TICKS = 2)
REQ-034 Scenario: pulse RESET_N low -> outputs FF/FF/0 immediately; after release, AN = 8'hFD 5 cycles later.
REQ-035 Scenario: INPUT, CODE = 16'h0937, CODE_BIT = 2 -> expected responses:
- AN0 shows SEG = 8'hF8 and AN1 shows SEG = 8'hB0.
- AN2 and AN3 show SEG = 8'hBF.
- LED[3:0] = 4'b0011.
REQ-036 Scenario: ERROR, ERROR_TIME = 2 -> digit 0 shows SEG = 8'hA4 and LED[13:12] = 2'b10.
REQ-037 Scenario: ALARM held 16 ticks -> LED alternates FFFF/0000 every 2 ticks, and SEG = 8'h00 on the lit digits.
REQ-038 Scenario: run 9 ticks in WAIT -> AN walks FE..7F, then FE; each AN value is held exactly 4 cycles.
REQ-039 Scenario: STATE = 7 -> AN = 8'hFF and LED = 0 within 2 cycles; drive RESET_N low mid-ALARM -> outputs clear asynchronously.
